// File: rtl/common_types_pkg.sv
// Shared types and packing constants for the front-end sample packer.
// FEM_PACK_2BIT_EN selects 2-bit {sign,mag} samples (4 per byte) instead of 1-bit sign samples.
package common_types_pkg;

  typedef logic [7:0] byte_t;

`ifdef FEM_PACK_2BIT_EN
  localparam int SAMPLES_PER_BYTE = 4;
`else
  localparam int SAMPLES_PER_BYTE = 8;
`endif

  localparam int BITS_PER_SAMPLE = 8 / SAMPLES_PER_BYTE;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO; head is valid whenever not empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module byte_fifo
  import common_types_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic  clk,
  input  logic  nrst,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output byte_t head,
  output logic  empty,
  output logic  full
);

  localparam int AW = $clog2(DEPTH);

  byte_t       mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/fem_sample_packer.sv
// Decimates front-end samples and packs them MSB-first into bytes queued for a UART.
// Define FEM_PACK_2BIT_EN to pack {samp_sign, samp_mag} pairs instead of sign bits only.
module fem_sample_packer
  import common_types_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DECIM      = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        sample_en,
  input  logic        samp_sign,
  input  logic        samp_mag,
  output byte_t       byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);
  localparam logic [2:0] BIT_LAST   = 3'(SAMPLES_PER_BYTE - 1);

  logic [7:0]  decim_cnt_reg;
  logic [2:0]  bit_cnt_reg;
  byte_t       shift_reg;
  byte_t       shift_next;
  logic        push_reg;
  byte_t       push_data_reg;
  logic        overflow_reg;
  logic [15:0] drop_count_reg;
  logic        take;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        drop;

  assign take = sample_en && (decim_cnt_reg == '0);

`ifdef FEM_PACK_2BIT_EN
  assign shift_next = {shift_reg[5:0], samp_sign, samp_mag};
`else
  logic unused_mag;
  assign unused_mag = samp_mag;
  assign shift_next = {shift_reg[6:0], samp_sign};
`endif

  assign pop  = !fifo_empty && byte_ready;
  assign drop = push_reg && fifo_full && !pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      decim_cnt_reg  <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      push_reg       <= 1'b0;
      push_data_reg  <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      push_reg <= 1'b0;
      if (!sample_en) begin
        // Partial byte is abandoned; a pending completed byte still goes out.
        decim_cnt_reg <= '0;
        bit_cnt_reg   <= '0;
        shift_reg     <= '0;
      end else begin
        decim_cnt_reg <= (decim_cnt_reg == DECIM_LAST) ? '0 : decim_cnt_reg + 8'd1;
        if (take) begin
          if (bit_cnt_reg == BIT_LAST) begin
            push_reg      <= 1'b1;
            push_data_reg <= shift_next;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            shift_reg   <= shift_next;
          end
        end
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (push_reg),
    .push_data(push_data_reg),
    .pop      (pop),
    .head     (byte_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign byte_valid = !fifo_empty;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_fem_sample_packer.sv
// Directed self-checking bench for fem_sample_packer (DECIM=1 and DECIM=3 instances).
module tb_fem_sample_packer;
  import common_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, sample_en, samp_sign, samp_mag, byte_ready;
  byte_t       byte_data;
  logic        byte_valid, overflow;
  logic [15:0] drop_count;

  logic        sample_en3, samp_sign3, samp_mag3, byte_ready3;
  byte_t       byte_data3;
  logic        byte_valid3, overflow3;
  logic [15:0] drop_count3;

  int    tests = 0;
  int    fails = 0;
  byte_t vals [18];

  fem_sample_packer #(.FIFO_DEPTH(16), .DECIM(1)) dut (
    .clk(clk), .nrst(nrst), .sample_en(sample_en), .samp_sign(samp_sign),
    .samp_mag(samp_mag), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .overflow(overflow), .drop_count(drop_count)
  );

  fem_sample_packer #(.FIFO_DEPTH(16), .DECIM(3)) dut3 (
    .clk(clk), .nrst(nrst), .sample_en(sample_en3), .samp_sign(samp_sign3),
    .samp_mag(samp_mag3), .byte_data(byte_data3), .byte_valid(byte_valid3),
    .byte_ready(byte_ready3), .overflow(overflow3), .drop_count(drop_count3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One taken sample per tick (DECIM=1), MSB first.
  task automatic send_byte(input byte_t v);
    sample_en = 1'b1;
`ifdef FEM_PACK_2BIT_EN
    for (int i = 3; i >= 0; i--) begin
      samp_sign = v[2*i+1];
      samp_mag  = v[2*i];
      tick();
    end
`else
    for (int i = 7; i >= 0; i--) begin
      samp_sign = v[i];
      samp_mag  = ~v[i];
      tick();
    end
`endif
  endtask

  initial begin
    int n, first, last;
    nrst = 1'b0; sample_en = 1'b1; samp_sign = 1'b1; samp_mag = 1'b1; byte_ready = 1'b1;
    sample_en3 = 1'b0; samp_sign3 = 1'b1; samp_mag3 = 1'b1; byte_ready3 = 1'b1;
    repeat (3) tick();
    check("rst_valid",    16'(byte_valid), 16'h0);
    check("rst_data",     16'(byte_data),  16'h00);
    check("rst_overflow", 16'(overflow),   16'h0);
    check("rst_drops",    drop_count,      16'h0);
    check("rst_valid3",   16'(byte_valid3), 16'h0);
    sample_en = 1'b0;
    nrst = 1'b1;

    // Basic packing and push latency
    send_byte(8'hB2);
    check("b2_not_yet", 16'(byte_valid), 16'h0);
    sample_en = 1'b0;
    tick();
    check("b2_valid", 16'(byte_valid), 16'h1);
    check("b2_data",  16'(byte_data),  16'hB2);
    tick();
    check("b2_popped", 16'(byte_valid), 16'h0);

    // Partial byte discarded on sample_en drop
    sample_en = 1'b1; samp_sign = 1'b0; samp_mag = 1'b0;
    for (int i = 0; i < SAMPLES_PER_BYTE - 3; i++) tick();
    sample_en = 1'b0;
    tick();
    check("partial_none", 16'(byte_valid), 16'h0);
    send_byte(8'hFF);
    sample_en = 1'b0;
    tick();
    check("partial_valid", 16'(byte_valid), 16'h1);
    check("partial_data",  16'(byte_data),  16'hFF);
    tick();
    check("partial_only_one", 16'(byte_valid), 16'h0);

    // Overflow: 18 bytes into a 16-deep FIFO with no reader
    byte_ready = 1'b0;
    for (int k = 0; k < 18; k++) begin
      vals[k] = 8'(k * 37 + 5);
      send_byte(vals[k]);
    end
    sample_en = 1'b0;
    tick();
    check("ovf_flag",  16'(overflow),   16'h1);
    check("ovf_drops", drop_count,      16'd2);
    check("ovf_valid", 16'(byte_valid), 16'h1);
    check("ovf_head",  16'(byte_data),  16'(vals[0]));
    tick();
    check("ovf_head_stable", 16'(byte_data), 16'(vals[0]));
    byte_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovf_out%0d", k), 16'(byte_data), 16'(vals[k]));
      tick();
    end
    check("ovf_drained", 16'(byte_valid), 16'h0);
    check("ovf_sticky",  16'(overflow),   16'h1);

    // Full FIFO, push and pop on the same edge: no drop
    byte_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_byte(vals[k] ^ 8'hFF);
    send_byte(8'h3C);
    byte_ready = 1'b1;
    sample_en = 1'b0;
    tick();
    byte_ready = 1'b0;
    check("simul_drops", drop_count, 16'd2);
    check("simul_valid", 16'(byte_valid), 16'h1);
    byte_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      check($sformatf("simul_out%0d", k), 16'(byte_data), 16'(vals[k] ^ 8'hFF));
      tick();
    end
    check("simul_last", 16'(byte_data), 16'h3C);
    tick();
    check("simul_drained", 16'(byte_valid), 16'h0);

    // Asynchronous reset mid-byte with data buffered
    byte_ready = 1'b0;
    send_byte(8'h77);
    samp_sign = 1'b1; samp_mag = 1'b1;
    repeat (2) tick();
    nrst = 1'b0;
    #2;
    check("arst_valid",    16'(byte_valid), 16'h0);
    check("arst_data",     16'(byte_data),  16'h00);
    check("arst_overflow", 16'(overflow),   16'h0);
    check("arst_drops",    drop_count,      16'h0);
    sample_en = 1'b0;
    tick();
    nrst = 1'b1;
    send_byte(8'h5A);
    sample_en = 1'b0;
    tick();
    check("post_rst_valid", 16'(byte_valid), 16'h1);
    check("post_rst_data",  16'(byte_data),  16'h5A);
    byte_ready = 1'b1;
    tick();
    check("post_rst_empty", 16'(byte_valid), 16'h0);

`ifdef FEM_PACK_2BIT_EN
    sample_en = 1'b1;
    samp_sign = 1'b1; samp_mag = 1'b1; tick();
    samp_sign = 1'b0; samp_mag = 1'b1; tick();
    samp_sign = 1'b1; samp_mag = 1'b0; tick();
    samp_sign = 1'b0; samp_mag = 0;    tick();
    sample_en = 1'b0;
    tick();
    check("pack2_valid", 16'(byte_valid), 16'h1);
    check("pack2_data",  16'(byte_data),  16'hD8);
    tick();
`endif

    // Decimation by 3: one byte per 3*SAMPLES_PER_BYTE clocks
    n = 0; first = 0; last = 0;
    sample_en3 = 1'b1;
    for (int t = 1; t <= 6 * SAMPLES_PER_BYTE; t++) begin
      tick();
      if (byte_valid3) begin
        n++;
        if (first == 0) first = t;
        last = t;
        check($sformatf("decim_data_t%0d", t), 16'(byte_data3), 16'hFF);
      end
    end
    sample_en3 = 1'b0;
    check("decim_count",  16'(n),            16'd2);
    check("decim_first",  16'(first),        16'(3 * (SAMPLES_PER_BYTE - 1) + 2));
    check("decim_period", 16'(last - first), 16'(3 * SAMPLES_PER_BYTE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fem_sample_packer.md
FEM_SAMPLE_PACKER -- requirements
Module: fem_sample_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, number of packed bytes buffered (power of two, 4..256).
REQ-002 The block SHALL have parameter DECIM, default 1, keep one sample every DECIM clocks (1..255).
REQ-003 The block SHALL have port clk  input  1  front-end sample clock (19.2 MHz), sole clock.
REQ-004 The block SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port sample_en  input  1  recording enable.
REQ-006 The block SHALL have port samp_sign  input  1  I-channel sign bit from front end.
REQ-007 The block SHALL have port samp_mag  input  1  I-channel magnitude bit; used only with FEM_PACK_2BIT_EN.
REQ-008 The block SHALL have port byte_data  output  8  head-of-FIFO byte toward UART transmitter.
REQ-009 The block SHALL have port byte_valid  output  1  byte_data is valid.
REQ-010 The block SHALL have port byte_ready  input  1  downstream accepts byte.
REQ-011 The block SHALL have port overflow  output  1  sticky, a packed byte was dropped.
REQ-012 The block SHALL have port drop_count  output  16  number of dropped bytes, saturating.

Function
REQ-013 A decimation counter SHALL run 0..DECIM-1 while sample_en=1, and SHALL hold at 0 while sample_en=0; a sample is taken when it equals 0 and sample_en=1.
REQ-014 Samples SHALL pack MSB-first: the first sample of a byte lands in bit 7.
REQ-015 In 1-bit mode each taken sample SHALL contribute samp_sign; 8 samples SHALL form one byte.
REQ-016 The completed byte SHALL be written to the FIFO on the clock edge after the final sample is taken (push latency 1 cycle).
REQ-017 Deasserting sample_en mid-byte SHALL discard the partial byte and zero the bit counter; the FIFO content SHALL be kept.
REQ-018 The FIFO SHALL be first-word-fall-through: byte_valid = not empty; byte_data SHALL be stable while byte_valid=1 and byte_ready=0.
REQ-019 A transfer SHALL occur when byte_valid and byte_ready are both 1 on a rising clk edge; byte_valid SHALL NOT depend combinationally on byte_ready.
REQ-020 A push to a full FIFO without a simultaneous pop SHALL drop the byte, set overflow, and increment drop_count saturating at 16'hFFFF.
REQ-021 A push and pop in the same cycle on a full FIFO SHALL both succeed with no drop; on an empty FIFO a push SHALL make byte_valid=1 on the next cycle.
REQ-022 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH using one extra pointer bit for full/empty discrimination.
REQ-023 overflow and drop_count SHALL clear only by reset.

Reset
REQ-024 While nrst=0: byte_valid=0, byte_data=8'h00, overflow=0, drop_count=0, FIFO empty, bit and decimation counters 0, shift register 0.
REQ-025 Reset asserted mid-byte or mid-transfer SHALL discard all buffered data immediately; the first byte after release SHALL start with a fresh bit 7.

Configuration
REQ-026 With macro FEM_PACK_2BIT_EN defined, each taken sample SHALL contribute {samp_sign, samp_mag} (sign in the higher bit), 4 samples per byte.
REQ-027 Without FEM_PACK_2BIT_EN, 1-bit mode SHALL apply and samp_mag SHALL be ignored.

Structure
REQ-028 common_types_pkg SHALL hold typedef byte_t (logic [7:0]) and constant SAMPLES_PER_BYTE selected by FEM_PACK_2BIT_EN.
REQ-029 The FIFO SHALL be a separate sub-module named byte_fifo (sync, FWFT, parameter DEPTH); packing and decimation SHALL be in fem_sample_packer.

Verification
REQ-030 DECIM=1, 1-bit, byte_ready=1, samp_sign sequence 1,0,1,1,0,0,1,0 -> byte_data=8'hB2 with byte_valid=1 on the 2nd edge after the 8th sample.
REQ-031 DECIM=3, samp_sign=1 constant -> one byte 8'hFF per 24 clocks.
REQ-032 byte_ready=0, FIFO_DEPTH=16, 18 bytes produced -> 16 buffered, overflow=1, drop_count=2; then byte_ready=1 -> first 16 bytes out in order.
REQ-033 FIFO full with byte_ready=1 asserted on the cycle of a push -> no drop, drop_count unchanged.
REQ-034 sample_en deasserted after 5 samples, reasserted, 8 samples of 1 -> only 8'hFF emitted.
REQ-035 FEM_PACK_2BIT_EN defined, {sign,mag} = 11,01,10,00 -> byte_data=8'hD8.
